// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_pkg;

  localparam int PC_W         = 32;
  localparam int INSTR_W      = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int CHANNELS_DEF = 3;
  localparam int ADDR_W_DEF   = 5;
  localparam int FLAG_W_DEF   = 1;

  // A bubble carries an all-zero instruction, which decodes as sll $0,$0,0.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

  // Default-width stage entry; parametrised instances build their own
  // struct with the same field order and hand it to the entry slot.
  typedef struct packed {
    logic [PC_W-1:0]                    pc;
    logic [INSTR_W-1:0]                 instr;
    logic [CHANNELS_DEF*DATA_W_DEF-1:0] data;
    logic [ADDR_W_DEF-1:0]              addr;
    logic [FLAG_W_DEF-1:0]              flag;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_stage_entry.sv
// One valid+payload slot; payload is forced to zero whenever the slot is empty.
// Latency: load/clear take effect at the next rising edge.
// Backpressure: none here; the owner decides when to load or clear.
import pipe_pkg::*;

module pipe_stage_entry #(
  parameter type entry_t = pipe_entry_t
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   clear,
  input  logic   load,
  input  logic   load_vld,
  input  entry_t d,
  output logic   vld,
  output entry_t q
);

  // Slot register: reset/clear win over load; loading "empty" zeroes the payload.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (load) begin
      vld <= load_vld;
      q   <= load_vld ? d : '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register: main slot drives outputs, skid slot absorbs one item.
// Latency: 1 cycle from accept to out_*; 1 item/cycle while out_ready is high.
// Backpressure: in_ready = !skid_vld straight from a flop, no path from out_ready.
import pipe_pkg::*;

module pipe_stage_reg #(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int FLAG_W   = FLAG_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic [FLAG_W-1:0]          in_flag,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [CHANNELS*DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic [FLAG_W-1:0]          out_flag,
  output logic [CNT_W-1:0]           stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]            pc;
    logic [INSTR_W-1:0]         instr;
    logic [CHANNELS*DATA_W-1:0] data;
    logic [ADDR_W-1:0]          addr;
    logic [FLAG_W-1:0]          flag;
  } stage_entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  stage_entry_t in_entry;
  stage_entry_t main_d, main_q, skid_d, skid_q;
  logic         main_vld, skid_vld;
  logic         main_load, main_load_vld;
  logic         skid_load, skid_load_vld;
  logic         main_free, accept;

  assign in_entry.pc    = in_pc;
  assign in_entry.instr = in_instr;
  assign in_entry.data  = in_data;
  assign in_entry.addr  = in_addr;
  assign in_entry.flag  = in_flag;

  assign in_ready = !skid_vld;
  assign accept   = in_valid && in_ready;

  // Slot steering: main refills from skid first to keep order; skid catches
  // an accepted item only when main cannot take it this edge.
  always_comb begin
    main_free     = !main_vld || out_ready;
    main_load     = main_free;
    main_load_vld = skid_vld || accept;
    main_d        = skid_vld ? skid_q : in_entry;
    skid_load     = main_free ? skid_vld : accept;
    skid_load_vld = accept;
    skid_d        = in_entry;
  end

  pipe_stage_entry #(.entry_t(stage_entry_t)) u_main (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (main_load),
    .load_vld (main_load_vld),
    .d        (main_d),
    .vld      (main_vld),
    .q        (main_q)
  );

  pipe_stage_entry #(.entry_t(stage_entry_t)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .load     (skid_load),
    .load_vld (skid_load_vld),
    .d        (skid_d),
    .vld      (skid_vld),
    .q        (skid_q)
  );

  // Main slot is zero when empty, so the outputs are already a clean bubble.
  assign out_valid = main_vld;
  assign out_pc    = main_q.pc;
  assign out_instr = main_vld ? main_q.instr : NOP_INSTR;
  assign out_data  = main_q.data;
  assign out_addr  = main_q.addr;
  assign out_flag  = main_q.flag;

  // Saturating count of edges where a valid output is held back (flush edges excluded).
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (main_vld && !out_ready && !flush && stall_cnt != CNT_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed + random bench for pipe_stage_reg with a queue scoreboard.
// Latency: checks outputs every negedge against the queue head.
// Backpressure: in_ready expected high whenever fewer than two items are held.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [95:0] data;
    logic [4:0]  addr;
    logic [0:0]  flag;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [95:0] in_data;
  logic [4:0]  in_addr;
  logic [0:0]  in_flag;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [95:0] out_data;
  logic [4:0]  out_addr;
  logic [0:0]  out_flag;
  logic [3:0]  stall_cnt;

  item_t      sb[$];
  logic [3:0] scnt;
  int         vectors = 0;
  int         fails   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W   (32),
    .CHANNELS (3),
    .FLAG_W   (1),
    .ADDR_W   (5),
    .CNT_W    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .in_flag   (in_flag),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .out_flag  (out_flag),
    .stall_cnt (stall_cnt)
  );

  function automatic item_t mk(input logic [31:0] pc, input logic [31:0] instr);
    item_t it;
    it.pc    = pc;
    it.instr = instr;
    it.data  = {pc ^ 32'hA5A5_0000, ~pc, pc + 32'h1111};
    it.addr  = pc[6:2];
    it.flag  = pc[2];
    return it;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: check outputs at negedge, drive new inputs, advance the model
  // to what the following posedge should produce.
  task automatic step(input logic iv, input logic ordy, input logic fl, input logic rst,
                      input logic [31:0] pc, input logic [31:0] instr);
    item_t it;
    item_t exp_it;
    logic  exp_rdy;
    logic  exp_vld;
    logic  acc;
    logic  rel;
    @(negedge clk);
    exp_rdy = (sb.size() < 2);
    exp_vld = (sb.size() > 0);
    exp_it  = exp_vld ? sb[0] : '0;
    chk("in_ready",  128'(in_ready),  128'(exp_rdy));
    chk("out_valid", 128'(out_valid), 128'(exp_vld));
    chk("out_pc",    128'(out_pc),    128'(exp_it.pc));
    chk("out_instr", 128'(out_instr), 128'(exp_it.instr));
    chk("out_data",  128'(out_data),  128'(exp_it.data));
    chk("out_addr",  128'(out_addr),  128'(exp_it.addr));
    chk("out_flag",  128'(out_flag),  128'(exp_it.flag));
    chk("stall_cnt", 128'(stall_cnt), 128'(scnt));
    it        = mk(pc, instr);
    in_valid  = iv;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    in_pc     = it.pc;
    in_instr  = it.instr;
    in_data   = it.data;
    in_addr   = it.addr;
    in_flag   = it.flag;
    acc = iv && exp_rdy;
    rel = exp_vld && ordy;
    if (rst) begin
      sb.delete();
      scnt = 4'h0;
    end else if (fl) begin
      sb.delete();
    end else begin
      if (exp_vld && !ordy && scnt != 4'hF) scnt = scnt + 4'h1;
      if (rel) void'(sb.pop_front());
      if (acc) sb.push_back(it);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_instr = '0; in_data = '0; in_addr = '0; in_flag = '0;
    scnt = 4'h0;
    repeat (3) @(posedge clk);

    // Reset state checked by the first step; then a single item.
    step(1, 1, 0, 0, 32'h3000, 32'h2401_0005);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);

    // Back-to-back stream of 8 items with no backpressure.
    for (int i = 0; i < 8; i++)
      step(1, 1, 0, 0, 32'h3000 + 32'(4 * i), 32'h2401_0000 + 32'(i));
    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);

    // A held, B to skid, C refused, then drain A then B.
    step(0, 1, 0, 1, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h4000, 32'h8C22_0004);
    step(1, 0, 0, 0, 32'h4004, 32'hAC22_0008);
    step(1, 0, 0, 0, 32'h4008, 32'h1000_FFFF);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);

    // Main and skid full, flush with a new item offered.
    step(0, 1, 0, 1, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h5000, 32'h0000_0020);
    step(1, 0, 0, 0, 32'h5004, 32'h0000_0021);
    step(1, 0, 1, 0, 32'h5008, 32'h0000_0022);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);

    // Long stall: 4-bit counter must saturate at 4'hF.
    step(0, 1, 0, 1, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h6000, 32'h2402_0007);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);

    // Reset together with flush while skid is full.
    step(1, 0, 0, 0, 32'h7000, 32'h0000_0030);
    step(1, 0, 0, 0, 32'h7004, 32'h0000_0031);
    step(1, 0, 1, 1, 32'h7008, 32'h0000_0032);
    step(0, 1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 0, 32'h0, 32'h0);

    // Random valid/ready/flush traffic for ordering and no loss/duplication.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 31) == 0), 1'b0,
           $urandom, $urandom);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
